// File: rtl/prog_loader.sv
// Byte-serial program loader: length header, LE words, core release.
// Optional trailing checksum when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int WORD   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              stall_o,
  output logic              mem_write,
  output logic [WORD-1:0]   mem_in,
  output logic [ADDR_W-1:0] load_addr,
  output logic              done,
  output logic              error
);

  localparam int CW = ADDR_W + 1;
  localparam logic [31:0] MAXN = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DRAIN,
    RUN,
    ERR
  } state_t;

  state_t state, nstate;

  logic [1:0]    bcnt;
  logic [23:0]   asm_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] num;
  logic [31:0]   word;
  logic          take;
  logic          last;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD-1:0] sum;
`endif

  assign take = rx_valid & rx_ready;
  assign last = take & (bcnt == 2'd3);
  // Fourth byte completes the word straight from the input bus.
  assign word = {rx_data, asm_q};

  assign stall_o = (state != RUN);
  assign done    = (state == RUN);
  assign error   = (state == ERR);

  always_comb begin
    nstate   = state;
    rx_ready = 1'b0;
    unique case (state)
      IDLE: nstate = HDR;
      HDR: begin
        rx_ready = 1'b1;
        if (last) begin
          if (word > MAXN)
            nstate = ERR;
          else if (word == '0)
`ifdef LOADER_CHECKSUM_EN
            nstate = CHK;
`else
            nstate = RUN;
`endif
          else
            nstate = LOAD;
        end
      end
      LOAD: begin
        rx_ready = 1'b1;
        if (last && cnt == num - CW'(1))
`ifdef LOADER_CHECKSUM_EN
          nstate = CHK;
`else
          nstate = DRAIN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        if (last)
          nstate = (WORD'(word) == sum) ? RUN : ERR;
      end
`endif
      DRAIN: nstate = RUN;
      RUN:   nstate = RUN;
      ERR:   nstate = ERR;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bcnt      <= '0;
      asm_q     <= '0;
      cnt       <= '0;
      num       <= '0;
      mem_write <= 1'b0;
      mem_in    <= '0;
      load_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state     <= nstate;
      mem_write <= 1'b0;
      if (take) begin
        bcnt  <= bcnt + 2'd1;
        asm_q <= {rx_data, asm_q[23:8]};
      end
      if (last && state == HDR)
        num <= word[CW-1:0];
      if (last && state == LOAD) begin
        mem_in    <= WORD'(word);
        mem_write <= 1'b1;
        load_addr <= cnt[ADDR_W-1:0];
        cnt       <= cnt + CW'(1);
`ifdef LOADER_CHECKSUM_EN
        sum       <= sum + WORD'(word);
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: random images against a word-list reference.
// Build with LOADER_CHECKSUM_EN to cover the checksum trailer.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        stall_o;
  logic        mem_write;
  logic [31:0] mem_in;
  logic [7:0]  load_addr;
  logic        done;
  logic        error;

  prog_loader #(.WORD(32), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .stall_o(stall_o), .mem_write(mem_write), .mem_in(mem_in),
    .load_addr(load_addr), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] got_d[$];
  int got_a[$];
  int dbl = 0;
  int overlap = 0;
  int early = 0;
  int cyc = 0;
  int rel = -1;
  logic prev_mw = 1'b0;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write) begin
      got_d.push_back(mem_in);
      got_a.push_back(int'(load_addr));
    end
    if (mem_write && prev_mw) dbl++;
    if (mem_write && !stall_o) overlap++;
    if (reset && !stall_o && rel < 0) rel = cyc;
    prev_mw = mem_write;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got_d.delete();
    got_a.delete();
    dbl = 0;
    overlap = 0;
    early = 0;
    rel = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int t;
    bit acc;
    if (!stall_o) early++;
    rx_data = b;
    rx_valid = 1'b1;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 64) begin
      acc = rx_ready;
      @(negedge clk);
      t++;
    end
    rx_valid = 1'b0;
    ok = acc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic make_stream(input logic [31:0] n, input logic [31:0] w[$],
                             input logic [31:0] ck, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
    foreach (w[k])
      for (int i = 0; i < 4; i++) q.push_back(w[k][8*i +: 8]);
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) q.push_back(ck[8*i +: 8]);
`endif
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int gap,
                             input bit rnd, output int miss);
    bit ok;
    int g;
    miss = 0;
    for (int i = 0; i < q.size() && miss == 0; i++) begin
      g = rnd ? int'($urandom_range(0, 3)) : gap;
      send_byte(q[i], g, ok);
      if (!ok) miss = q.size() - i;
    end
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!done && !error && t < 32) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load(input string name, input logic [31:0] w[$],
                           input int gap, input bit rnd);
    logic [7:0] q[$];
    logic [31:0] sum;
    int miss;
    int exp_rel;
    sum = '0;
    foreach (w[i]) sum += w[i];
    do_reset();
    make_stream(32'(w.size()), w, sum, q);
    send_stream(q, gap, rnd, miss);
    wait_end();
    checks++;
    if (miss !== 0) begin
      errors++;
      $display("FAIL %s accept: %0d bytes unaccepted, need 0", name, miss);
    end
    checks++;
    if ({done, error, stall_o, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL %s status: done/err/stall/rdy=%b need 1000", name,
               {done, error, stall_o, rx_ready});
    end
    checks++;
    if (got_d.size() !== w.size()) begin
      errors++;
      $display("FAIL %s writes: got %0d need %0d", name, got_d.size(), w.size());
    end else begin
      foreach (w[i]) begin
        checks++;
        if (got_d[i] !== w[i] || got_a[i] !== (i % 256)) begin
          errors++;
          $display("FAIL %s word%0d: got %h@%0d need %h@%0d", name, i,
                   got_d[i], got_a[i], w[i], i % 256);
        end
      end
    end
    checks++;
    if (dbl !== 0 || overlap !== 0 || early !== 0) begin
      errors++;
      $display("FAIL %s pulse: dbl=%0d overlap=%0d early=%0d need 0", name,
               dbl, overlap, early);
    end
    if (gap == 0 && !rnd && w.size() > 0) begin
`ifdef LOADER_CHECKSUM_EN
      exp_rel = 1 + 4 + 4 * w.size() + 4;
`else
      exp_rel = 1 + 4 + 4 * w.size() + 1;
`endif
      checks++;
      if (rel !== exp_rel) begin
        errors++;
        $display("FAIL %s release: cycle %0d need %0d", name, rel, exp_rel);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    @(negedge clk);
    checks++;
    if ({stall_o, rx_ready, mem_write, done, error} !== 5'b10000 ||
        mem_in !== '0 || load_addr !== '0) begin
      errors++;
      $display("FAIL reset_vals: s/r/w/d/e=%b in=%h a=%h need 10000 0 0",
               {stall_o, rx_ready, mem_write, done, error}, mem_in, load_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rx_ready !== 1'b0 || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: rdy=%b stall=%b need 0 1", rx_ready, stall_o);
    end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hdr: rdy=%b need 1", rx_ready);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_two_word();
    logic [31:0] w[$];
    w = '{32'h20000013, 32'h12345678};
    test_load("two_word", w, 0, 1'b0);
  endtask

  task automatic test_gapped();
    logic [31:0] w[$];
    w = '{32'h20000013, 32'h12345678};
    test_load("gapped", w, 3, 1'b0);
  endtask

  task automatic test_boundary();
    logic [31:0] w[$];
    w = {};
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    test_load("max256", w, 0, 1'b0);
    checks++;
    if (got_a.size() != 256 || got_a[255] !== 255) begin
      errors++;
      $display("FAIL max256_last_addr: size %0d need 256 ending at 255",
               got_a.size());
    end
    w = {};
    test_load("zero", w, 0, 1'b0);
  endtask

  task automatic test_overflow(input logic [31:0] n);
    logic [31:0] w[$];
    logic [7:0] q[$];
    bit ok;
    int miss;
    w = {};
    do_reset();
    make_stream(n, w, 32'h0, q);
    q = q[0:3];
    send_stream(q, 0, 1'b0, miss);
    repeat (4) @(negedge clk);
    checks++;
    if ({done, error, stall_o, rx_ready} !== 4'b0110 || miss !== 0) begin
      errors++;
      $display("FAIL overflow %h: done/err/stall/rdy=%b miss=%0d need 0110 0",
               n, {done, error, stall_o, rx_ready}, miss);
    end
    send_byte(8'h11, 0, ok);
    checks++;
    if (ok !== 1'b0 || got_d.size() !== 0) begin
      errors++;
      $display("FAIL overflow_hold %h: accepted=%b writes=%0d need 0 0",
               n, ok, got_d.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w[$];
    logic [7:0] q[$];
    bit ok;
    w = '{32'h20000013, 32'h12345678};
    do_reset();
    make_stream(32'd2, w, 32'h0, q);
    for (int i = 0; i < 6; i++) send_byte(q[i], 0, ok);
    reset = 1'b0;
    #1;
    checks++;
    if ({stall_o, rx_ready, mem_write, done, error} !== 5'b10000 ||
        mem_in !== '0 || load_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset: s/r/w/d/e=%b in=%h a=%h need 10000 0 0",
               {stall_o, rx_ready, mem_write, done, error}, mem_in, load_addr);
    end
    test_load("after_reset", w, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 12);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      test_load($sformatf("rand%0d", it), w, 0, 1'b1);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    logic [31:0] w[$];
    logic [7:0] q[$];
    int miss;
    w = '{32'h20000013, 32'h12345678};
    do_reset();
    make_stream(32'd2, w, 32'h0, q);
    send_stream(q, 0, 1'b0, miss);
    wait_end();
    checks++;
    if ({done, error, stall_o} !== 3'b011 || got_d.size() !== 2) begin
      errors++;
      $display("FAIL cksum_bad: done/err/stall=%b writes=%0d need 011 2",
               {done, error, stall_o}, got_d.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_word();
    test_gapped();
    test_boundary();
    test_overflow(32'h00000101);
    test_overflow($urandom | 32'h00000200);
    test_mid_reset();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
